// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: fabric register port, DEPTH-entry transmit FIFO,
// programmable bit period (DIVISOR+1 cycles).
module uart_tx_peripheral #(
    parameter int unsigned DEPTH         = 8,
    parameter logic [15:0] RESET_DIVISOR = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write,
    input  logic        read,
    input  logic [9:0]  address,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overrun_q;
    logic [15:0]      divisor_q;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] period_q, period_d;
    logic        tx_d;

    logic        sel_data, sel_status, sel_div;
    logic        push, push_ok, pop;
    logic        fifo_empty, fifo_full;
    logic        bit_done;
    logic [31:0] count_ext;
    logic [3:0]  count_sat;
    logic [31:0] rdata_mux;
    logic        unused_bits;

    assign unused_bits = &{1'b0, address[9:2], byte_enable[3:2], writedata[31:16]};

    assign sel_data   = (address[1:0] == 2'd0);
    assign sel_status = (address[1:0] == 2'd1);
    assign sel_div    = (address[1:0] == 2'd2);

    assign fifo_empty = (count_q == CNT_W'(0));
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign push       = write & sel_data & byte_enable[0];
    // A full FIFO still accepts a push when the serialiser pops in the same cycle.
    assign push_ok    = push & (~fifo_full | pop);
    assign bit_done   = (bit_cnt_q == 16'd0);

    assign count_ext = 32'(count_q);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        rdata_mux = '0;
        case (address[1:0])
            2'd1:    rdata_mux = 32'({count_sat, overrun_q, (state_q != S_IDLE), fifo_full, fifo_empty});
            2'd2:    rdata_mux = 32'(divisor_q);
            default: rdata_mux = '0;
        endcase
    end

    // Serialiser next-state; the pop decision only looks at the count held this cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_cnt_q;
        period_d  = period_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr_q];
                    period_d  = divisor_q;
                    bit_cnt_d = divisor_q;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_cnt_d = period_q;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = period_q;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = mem[rd_ptr_q];
                        period_d  = divisor_q;
                        bit_cnt_d = divisor_q;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            bit_cnt_q <= '0;
            period_q  <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            bit_cnt_q <= bit_cnt_d;
            period_q  <= period_d;
            tx        <= tx_d;
            tx_busy   <= (state_q != S_IDLE) | ~fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Fabric register port; a simultaneous write wins and readdata holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readdata  <= '0;
            ready     <= 1'b0;
            overrun_q <= 1'b0;
            divisor_q <= RESET_DIVISOR;
        end else begin
            ready <= write | read;
            if (push & ~push_ok) begin
                overrun_q <= 1'b1;
            end
            if (write) begin
                if (sel_status && byte_enable[0] && writedata[3]) begin
                    overrun_q <= 1'b0;
                end
                if (sel_div && byte_enable[0]) divisor_q[7:0]  <= writedata[7:0];
                if (sel_div && byte_enable[1]) divisor_q[15:8] <= writedata[15:8];
            end else if (read) begin
                readdata <= rdata_mux;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Directed self-checking bench for uart_tx_peripheral: register map, framing, FIFO overrun, reset.
module tb_uart_tx_peripheral;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [9:0]  address = '0;
    logic [3:0]  byte_enable = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        ready;
    logic        tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    uart_tx_peripheral #(.DEPTH(8), .RESET_DIVISOR(16'd433)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write       (write),
        .read        (read),
        .address     (address),
        .byte_enable (byte_enable),
        .writedata   (writedata),
        .readdata    (readdata),
        .ready       (ready),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        write       = 1'b1;
        address     = {8'b0, a};
        byte_enable = be;
        writedata   = d;
        tick();
        write       = 1'b0;
        byte_enable = '0;
        check("wr_ready", 32'(ready), 32'd1);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        read    = 1'b1;
        address = {8'b0, a};
        tick();
        read    = 1'b0;
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check(tag, readdata, exp);
    endtask

    // Expected line level for bit slot idx of an 8N1 frame: start, 8 data LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] b2b [3];
        b2b[0] = 8'hA5;
        b2b[1] = 8'h3C;
        b2b[2] = 8'hFF;

        // Reset values
        repeat (2) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        rst_n = 1'b1;
        tick();
        bus_read(2'd1, 32'h0000_0001, "rst_status");
        bus_read(2'd2, 32'h0000_01B1, "rst_div");

        // Byte enables and access rules
        bus_write(2'd2, 4'b0010, 32'h1234_5678);
        bus_read(2'd2, 32'h0000_56B1, "be_div");
        bus_write(2'd0, 4'b1110, 32'h0000_00AB);
        bus_read(2'd1, 32'h0000_0001, "be_nopush");
        check("be_nopush_tx", 32'(tx), 32'd1);
        bus_write(2'd2, 4'b0000, 32'hFFFF_FFFF);
        bus_read(2'd2, 32'h0000_56B1, "be_zero");
        write = 1'b1; read = 1'b1; address = 10'd3; byte_enable = 4'hF; writedata = 32'hDEAD_BEEF;
        tick();
        write = 1'b0; read = 1'b0; byte_enable = '0;
        check("wr_rd_ready", 32'(ready), 32'd1);
        check("wr_rd_hold", readdata, 32'h0000_56B1);
        bus_read(2'd3, 32'd0, "reserved_rd");
        bus_read(2'd0, 32'd0, "data_rd");
        tick();
        check("ready_idle", 32'(ready), 32'd0);

        // Single frame, DIVISOR=3
        bus_write(2'd2, 4'b0011, 32'd3);
        bus_write(2'd0, 4'b0001, 32'h55);
        check("f1_pre_tx", 32'(tx), 32'd1);
        for (int k = 0; k < 40; k++) begin
            tick();
            check("f1_tx", 32'(tx), 32'(frame_bit(8'h55, k / 4)));
            if (k == 0 || k == 39) check("f1_busy", 32'(tx_busy), 32'd1);
        end
        repeat (3) tick();
        check("f1_busy_end", 32'(tx_busy), 32'd0);
        check("f1_tx_end", 32'(tx), 32'd1);

        // Back-to-back frames, DIVISOR=0
        bus_write(2'd2, 4'b0011, 32'd0);
        bus_write(2'd0, 4'b0001, 32'hA5);
        bus_write(2'd0, 4'b0001, 32'h3C);
        bus_write(2'd0, 4'b0001, 32'hFF);
        bus_read(2'd1, 32'h0000_0024, "b2b_count2");
        for (int i = 2; i < 30; i++) begin
            if (i > 2) tick();
            if (i == 11) begin
                read = 1'b0;
                check("b2b_count1", readdata, 32'h0000_0014);
            end
            check("b2b_tx", 32'(tx), 32'(frame_bit(b2b[i / 10], i % 10)));
            if (i == 10) begin
                read    = 1'b1;
                address = 10'd1;
            end
        end
        tick();
        check("b2b_tx_idle", 32'(tx), 32'd1);
        repeat (2) tick();
        check("b2b_busy_end", 32'(tx_busy), 32'd0);

        // Overrun with a very slow bit rate
        bus_write(2'd2, 4'b0011, 32'h0000_FFFF);
        for (int i = 0; i < 10; i++) bus_write(2'd0, 4'b0001, 32'(i + 1));
        bus_read(2'd1, 32'h0000_008E, "ovr_status");
        bus_write(2'd1, 4'b0001, 32'h0000_0008);
        bus_read(2'd1, 32'h0000_0086, "ovr_clear");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during DATA bit 3
        bus_write(2'd2, 4'b0011, 32'd3);
        bus_write(2'd0, 4'b0001, 32'h00);
        repeat (18) tick();
        check("mid_tx_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(2'd1, 32'h0000_0001, "post_rst_status");
        bus_read(2'd2, 32'h0000_01B1, "post_rst_div");
        bus_write(2'd2, 4'b0011, 32'd1);
        bus_write(2'd0, 4'b0001, 32'hC3);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("post_rst_tx", 32'(tx), 32'(frame_bit(8'hC3, k / 2)));
        end
        repeat (3) tick();
        check("post_rst_busy_end", 32'(tx_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_peripheral.md
# uart_tx_peripheral

Memory-mapped UART transmitter that answers the data-fabric arbitrator as a peripheral, alongside the data RAM, switch and LEDR peripherals. The CPU writes bytes into an 8-entry transmit FIFO through the fabric. An internal 8N1 serialiser drains the FIFO onto a single TX pin at a programmable bit rate. Status and divisor registers are readable over the same fabric port.

## Interface
- DEPTH, 8: FIFO entries. Must be a power of 2, at least 2.
- RESET_DIVISOR, 433: reset value of DIVISOR. 50 MHz / 115200 baud gives 434 cycles per bit.

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  system clock (CLOCK_50)
- rst_n  in  1  asynchronous active-low reset
- write  in  1  single-cycle write strobe from the fabric master_write lane
- read  in  1  single-cycle read strobe from the fabric master_read lane
- address  in  10  fabric word address; only address[1:0] is decoded
- byte_enable  in  4  lane enables for writedata
- writedata  in  32  write data
- readdata  out  32  registered read data
- ready  out  1  one-cycle access-complete pulse
- tx  out  1  serial output, idle high
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty

## Operation
Register map by address[1:0]:
- 0 DATA
  - Write with byte_enable[0]=1 pushes writedata[7:0] into the FIFO.
  - If the FIFO is full, the byte is dropped and OVERRUN is set.
  - Reads return 0.
- 1 STATUS
  - Read fields: bit0 EMPTY, bit1 FULL, bit2 BUSY (FSM not IDLE), bit3 OVERRUN (sticky), bits[7:4] COUNT (FIFO occupancy, saturating at 15), other bits 0.
  - Write with byte_enable[0]=1 and writedata[3]=1 clears OVERRUN. Other bits are ignored.
- 2 DIVISOR
  - 16-bit field; bit period is DIVISOR+1 cycles.
  - Lane 0 writes bits[7:0]; lane 1 writes bits[15:8]; lanes 2 and 3 are ignored.
  - Reads return {16'b0, DIVISOR}.
- 3 reserved: reads return 0; writes have no effect.

Access rules:
- write and read asserted in the same cycle: the write is performed, the read is ignored, readdata holds its value, ready pulses once.
- A write with all byte_enable bits 0 changes nothing but still produces ready.

FIFO:
- Circular buffer with log2(DEPTH)-bit read and write pointers and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle when full: the push is accepted and the count is unchanged.
- The pop decision uses the count at the start of the cycle. A push into an empty FIFO is therefore popped no earlier than the next cycle.

Serialiser FSM, states IDLE, START, DATA, STOP:
- IDLE: tx=1. If the FIFO is non-empty:
  - pop the head byte into the shift register;
  - latch DIVISOR into the bit-period counter reload;
  - go to START.
- START: tx=0 for DIVISOR+1 cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0] for DIVISOR+1 cycles per bit, LSB first. After bit 7 go to STOP.
- STOP: tx=1 for DIVISOR+1 cycles.
  - At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- A DIVISOR write mid-frame takes effect at the next frame start only.
- Bit counter: 16-bit down-counter loaded with the latched divisor; the bit ends when it reaches 0. DIVISOR=0 gives a 1-cycle bit.

## Timing
- Reset values:
  - tx=1, tx_busy=0, ready=0, readdata=0;
  - FIFO empty, pointers 0, OVERRUN=0;
  - DIVISOR=RESET_DIVISOR; FSM in IDLE.
- Register access: a strobe in cycle N produces ready=1 and the valid readdata in cycle N+1. ready is 0 otherwise. There are no wait states.
- A write side effect (push, divisor, clear) is visible in state from cycle N+1.
- From IDLE with an empty FIFO, a DATA write in cycle N gives:
  - count=1 at N+1, pop at N+1;
  - tx falls at N+2 (START entered at N+2).
- Frame length is exactly 10*(latched DIVISOR+1) cycles. Back-to-back frames have no gap.
- tx_busy = (FSM != IDLE) | !EMPTY, registered. It falls the cycle after STOP completes with the FIFO empty.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously) and the FIFO contents are discarded.

## Test plan
- Reset values: after reset, read STATUS -> readdata=0x00000001 with ready at N+1; read DIVISOR -> 0x000001B1; tx=1.
- Single frame: write DIVISOR=3, then DATA=0x55 -> tx low from N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, then stop high 4 cycles; tx_busy high for 40 cycles plus 2 cycles of latency.
- Back-to-back frames: DIVISOR=0, write 0xA5, 0x3C, 0xFF in consecutive cycles -> 30 contiguous cycles of framed data with no idle gap; STATUS COUNT reads 2 then 1 as bytes are popped.
- Overrun: DIVISOR=0xFFFF, write 10 bytes quickly -> FULL=1, OVERRUN=1, COUNT=8 (the first byte is already in the shifter); writing STATUS with 0x8 clears OVERRUN only.
- Byte enables: write DIVISOR 0x12345678 with byte_enable=4'b0010 from reset -> DIVISOR=0x56B1; DATA write with byte_enable=4'b1110 -> no push, ready still pulses.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 at once, STATUS reads 0x1 after release, and the next write transmits a clean frame.
